// File: rtl/sfp_peer_frame_unpacker.sv
// Rebuilds the remote MPS nine-word status snapshot from 6-beat peer telemetry frames.
// Latency: snapshot and o_frame_valid update one cycle after the edge accepting beat5.
// Backpressure: none; s_peer_tready simply mirrors i_en, so every beat is taken while enabled.
module sfp_peer_frame_unpacker #(
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [63:0] s_peer_tdata,
  input  logic        s_peer_tvalid,
  output logic        s_peer_tready,
  output logic [31:0] o_status,
  output logic [31:0] o_intl,
  output logic [31:0] o_c,
  output logic [31:0] o_v,
  output logic [31:0] o_dc_c,
  output logic [31:0] o_dc_v,
  output logic [31:0] o_phase_r,
  output logic [31:0] o_phase_s,
  output logic [31:0] o_phase_t,
  output logic [7:0]  o_src_id,
  output logic [31:0] o_seq,
  output logic        o_frame_valid,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_hdr_err_cnt,
  output logic [15:0] o_crc_err_cnt,
  output logic [15:0] o_seq_err_cnt,
  output logic [15:0] o_timeout_cnt
);

  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_COMMIT
  } state_t;

  state_t        state, state_nxt;

  // shadow copy of the frame being assembled
  logic [7:0]    sh_id;
  logic [31:0]   sh_seq;
  logic [31:0]   sh_w [9];
  logic [2:0]    beat_idx;
  logic [31:0]   run_xor;
  logic [IW-1:0] idle_cnt;

  // published snapshot
  logic [31:0]   snap [9];
  logic          have_prior;

  logic [31:0]   hi_w, lo_w;
  logic          accept, hunt_rules, hdr_ok;
  logic          hdr_take, hdr_bad, last_beat, crc_ok, crc_bad, tmo, do_commit, seq_gap;

  assign s_peer_tready = i_en;
  assign hi_w          = s_peer_tdata[63:32];
  assign lo_w          = s_peer_tdata[31:0];

  // Event decode; COMMIT applies header-hunting rules so back-to-back frames are not lost
  always_comb begin
    accept     = s_peer_tvalid & i_en;
    hunt_rules = (state != S_DATA);
    hdr_ok     = (s_peer_tdata[63:48] == SYNC_WORD) && (s_peer_tdata[39:32] == 8'd9);
    hdr_take   = accept & hunt_rules & hdr_ok;
    hdr_bad    = accept & hunt_rules & ~hdr_ok;
    last_beat  = accept && (state == S_DATA) && (beat_idx == 3'd5);
    crc_ok     = ((run_xor ^ hi_w) == lo_w);
    crc_bad    = last_beat & ~crc_ok;
    tmo        = i_en && (state == S_DATA) && !accept && (idle_cnt == IW'(TIMEOUT - 1));
    // the frame is already fully checked when COMMIT is reached, so it publishes even if i_en drops
    do_commit  = (state == S_COMMIT);
    seq_gap    = have_prior && (sh_seq != (o_seq + 32'd1));
  end

  // Next-state selection
  always_comb begin
    state_nxt = S_HUNT;
    if (i_en) begin
      case (state)
        S_HUNT, S_COMMIT: state_nxt = hdr_take ? S_DATA : S_HUNT;
        S_DATA: begin
          if (last_beat)  state_nxt = crc_ok ? S_COMMIT : S_HUNT;
          else if (tmo)   state_nxt = S_HUNT;
          else            state_nxt = S_DATA;
        end
        default:          state_nxt = S_HUNT;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_HUNT;
    else        state <= state_nxt;
  end

  // Frame assembly: header latch, per-beat shadow store, running XOR and idle timer
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sh_id    <= '0;
      sh_seq   <= '0;
      beat_idx <= '0;
      run_xor  <= '0;
      idle_cnt <= '0;
      for (int i = 0; i < 9; i++) sh_w[i] <= '0;
    end else if (hdr_take) begin
      sh_id    <= s_peer_tdata[47:40];
      sh_seq   <= lo_w;
      beat_idx <= 3'd1;
      run_xor  <= hi_w ^ lo_w;
      idle_cnt <= '0;
    end else if (state == S_DATA && accept) begin
      case (beat_idx)
        3'd1:    begin sh_w[0] <= hi_w; sh_w[1] <= lo_w; end
        3'd2:    begin sh_w[2] <= hi_w; sh_w[3] <= lo_w; end
        3'd3:    begin sh_w[4] <= hi_w; sh_w[5] <= lo_w; end
        3'd4:    begin sh_w[6] <= hi_w; sh_w[7] <= lo_w; end
        default: sh_w[8] <= hi_w;
      endcase
      run_xor  <= run_xor ^ hi_w ^ lo_w;
      beat_idx <= beat_idx + 3'd1;
      idle_cnt <= '0;
    end else if (state == S_DATA) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Coherent snapshot publish: all words, id and sequence move on the same edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 9; i++) snap[i] <= '0;
      o_src_id      <= '0;
      o_seq         <= '0;
      o_frame_valid <= 1'b0;
      have_prior    <= 1'b0;
    end else begin
      o_frame_valid <= do_commit;
      if (do_commit) begin
        for (int i = 0; i < 9; i++) snap[i] <= sh_w[i];
        o_src_id   <= sh_id;
        o_seq      <= sh_seq;
        have_prior <= 1'b1;
      end
    end
  end

  // Link-health counters, all free-running and wrapping
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_frame_cnt   <= '0;
      o_hdr_err_cnt <= '0;
      o_crc_err_cnt <= '0;
      o_seq_err_cnt <= '0;
      o_timeout_cnt <= '0;
    end else begin
      if (do_commit)            o_frame_cnt   <= o_frame_cnt + 16'd1;
      if (do_commit && seq_gap) o_seq_err_cnt <= o_seq_err_cnt + 16'd1;
      if (hdr_bad)              o_hdr_err_cnt <= o_hdr_err_cnt + 16'd1;
      if (crc_bad)              o_crc_err_cnt <= o_crc_err_cnt + 16'd1;
      if (tmo)                  o_timeout_cnt <= o_timeout_cnt + 16'd1;
    end
  end

  assign o_status  = snap[0];
  assign o_intl    = snap[1];
  assign o_c       = snap[2];
  assign o_v       = snap[3];
  assign o_dc_c    = snap[4];
  assign o_dc_v    = snap[5];
  assign o_phase_r = snap[6];
  assign o_phase_s = snap[7];
  assign o_phase_t = snap[8];

endmodule

// File: tb/tb_sfp_peer_frame_unpacker.sv
`timescale 1ns/1ps
// Self-checking bench for sfp_peer_frame_unpacker.
// Table of frame vectors with absolute expected counters, plus hand sequences for
// timeout, idle gaps, enable drop and mid-frame reset; snapshots checked via a scoreboard.
module tb_sfp_peer_frame_unpacker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [63:0] s_peer_tdata;
  logic        s_peer_tvalid;
  logic        s_peer_tready;
  logic [31:0] o_status, o_intl, o_c, o_v, o_dc_c, o_dc_v, o_phase_r, o_phase_s, o_phase_t;
  logic [7:0]  o_src_id;
  logic [31:0] o_seq;
  logic        o_frame_valid;
  logic [15:0] o_frame_cnt, o_hdr_err_cnt, o_crc_err_cnt, o_seq_err_cnt, o_timeout_cnt;

  sfp_peer_frame_unpacker #(.SYNC_WORD(16'hA55A), .TIMEOUT(1024)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .s_peer_tdata(s_peer_tdata), .s_peer_tvalid(s_peer_tvalid), .s_peer_tready(s_peer_tready),
    .o_status(o_status), .o_intl(o_intl), .o_c(o_c), .o_v(o_v), .o_dc_c(o_dc_c),
    .o_dc_v(o_dc_v), .o_phase_r(o_phase_r), .o_phase_s(o_phase_s), .o_phase_t(o_phase_t),
    .o_src_id(o_src_id), .o_seq(o_seq), .o_frame_valid(o_frame_valid),
    .o_frame_cnt(o_frame_cnt), .o_hdr_err_cnt(o_hdr_err_cnt), .o_crc_err_cnt(o_crc_err_cnt),
    .o_seq_err_cnt(o_seq_err_cnt), .o_timeout_cnt(o_timeout_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // scoreboard of expected commits
  typedef struct {
    logic [8:0][31:0] w;
    logic [7:0]       id;
    logic [31:0]      seq;
    int               cyc;
  } exp_t;
  exp_t sbq[$];

  // model of the published snapshot
  logic [31:0] m_seq, m_status;

  // expected counters
  int e_frame, e_hdr, e_crc, e_seq, e_to;

  logic [63:0] beats [6];
  logic [8:0][31:0] cur_w;

  // Compare every committed snapshot against the oldest scoreboard entry
  always @(negedge i_clk) begin
    if (i_rst === 1'b1 && o_frame_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_commit", 64'd1, 64'd0);
      end else begin
        exp_t e;
        logic [8:0][31:0] act;
        e = sbq.pop_front();
        act = {o_phase_t, o_phase_s, o_phase_r, o_dc_v, o_dc_c, o_v, o_c, o_intl, o_status};
        for (int i = 0; i < 9; i++) chk($sformatf("snap_word%0d", i), act[i], e.w[i]);
        chk("snap_src_id", o_src_id, e.id);
        chk("snap_seq", o_seq, e.seq);
        chk("commit_latency", cyc, e.cyc);
      end
    end
  end

  task automatic build(input logic [15:0] sync, input logic [7:0] id, input logic [7:0] cnt,
                       input logic [31:0] seq, input logic [31:0] base, input bit bad);
    logic [63:0] hdr;
    logic [31:0] x;
    hdr = {sync, id, cnt, seq};
    x = hdr[63:32] ^ hdr[31:0];
    for (int i = 0; i < 9; i++) begin
      cur_w[i] = base + 32'(i + 1);
      x = x ^ cur_w[i];
    end
    if (bad) x = x ^ 32'd1;
    beats[0] = hdr;
    beats[1] = {cur_w[0], cur_w[1]};
    beats[2] = {cur_w[2], cur_w[3]};
    beats[3] = {cur_w[4], cur_w[5]};
    beats[4] = {cur_w[6], cur_w[7]};
    beats[5] = {cur_w[8], x};
  endtask

  // called at a negedge; presents the beat for exactly one rising edge
  task automatic drive_beat(input logic [63:0] d);
    s_peer_tdata  = d;
    s_peer_tvalid = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    s_peer_tvalid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [31:0] seq, input logic [31:0] base,
                            input bit bad, input int gap);
    exp_t e;
    build(16'hA55A, id, 8'd9, seq, base, bad);
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && gap > 0) idle(gap);
      if (i == 5 && !bad) begin
        e.w = cur_w; e.id = id; e.seq = seq; e.cyc = cyc + 2;
        sbq.push_back(e);
        m_seq = seq;
        m_status = cur_w[0];
      end
      drive_beat(beats[i]);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, o_frame_cnt, e_frame);
    chk({tag, "_hdr_err"}, o_hdr_err_cnt, e_hdr);
    chk({tag, "_crc_err"}, o_crc_err_cnt, e_crc);
    chk({tag, "_seq_err"}, o_seq_err_cnt, e_seq);
    chk({tag, "_timeout"}, o_timeout_cnt, e_to);
  endtask

  typedef struct {
    bit          hdr_only;
    logic [15:0] sync;
    logic [7:0]  id;
    logic [7:0]  cnt;
    logic [31:0] seq;
    logic [31:0] base;
    bit          bad;
    int          x_frame, x_hdr, x_crc, x_seq;
  } vec_t;
  vec_t vt[7];

  function automatic vec_t mk(input bit ho, input logic [15:0] sy, input logic [7:0] id,
                              input logic [7:0] cn, input logic [31:0] sq, input logic [31:0] bs,
                              input bit bd, input int f, input int h, input int c, input int s);
    vec_t v;
    v.hdr_only = ho; v.sync = sy; v.id = id; v.cnt = cn; v.seq = sq; v.base = bs; v.bad = bd;
    v.x_frame = f; v.x_hdr = h; v.x_crc = c; v.x_seq = s;
    return v;
  endfunction

  initial begin
    // bad checksum first so the snapshot is still all-zero afterwards
    vt[0] = mk(0, 16'hA55A, 8'h02, 8'd9, 32'd5, 32'h1000_0000, 1, 0, 0, 1, 0);
    vt[1] = mk(0, 16'hA55A, 8'h02, 8'd9, 32'd5, 32'h1000_0000, 0, 1, 0, 1, 0);
    vt[2] = mk(0, 16'hA55A, 8'h02, 8'd9, 32'd6, 32'h1100_0000, 0, 2, 0, 1, 0);
    vt[3] = mk(1, 16'h5AA5, 8'h02, 8'd9, 32'd7, 32'h0,         0, 2, 1, 1, 0);
    vt[4] = mk(1, 16'hA55A, 8'h02, 8'd8, 32'd7, 32'h0,         0, 2, 2, 1, 0);
    vt[5] = mk(0, 16'hA55A, 8'h03, 8'd9, 32'd8, 32'h2000_0000, 0, 3, 2, 1, 1);
    // data words that look like a valid header must not cause a resync
    vt[6] = mk(0, 16'hA55A, 8'h04, 8'd9, 32'd9, 32'hA55A_0008, 0, 4, 2, 1, 1);

    m_seq = 0; m_status = 0;
    e_frame = 0; e_hdr = 0; e_crc = 0; e_seq = 0; e_to = 0;
    i_rst = 1'b0; i_en = 1'b1; s_peer_tvalid = 1'b0; s_peer_tdata = '0;
    repeat (3) @(negedge i_clk);

    // reset state
    chk("rst_tready_follows_en", s_peer_tready, 1'b1);
    chk("rst_snapshot_zero", |{o_status, o_intl, o_c, o_v, o_dc_c, o_dc_v, o_phase_r,
                               o_phase_s, o_phase_t, o_src_id, o_seq, o_frame_valid}, 1'b0);
    check_counters("rst");
    i_en = 1'b0; #1;
    chk("rst_tready_en_low", s_peer_tready, 1'b0);
    i_en = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    idle(2);

    // table-driven frames
    for (int k = 0; k < 7; k++) begin
      if (vt[k].hdr_only) begin
        build(vt[k].sync, vt[k].id, vt[k].cnt, vt[k].seq, vt[k].base, 0);
        drive_beat(beats[0]);
      end else begin
        send_frame(vt[k].id, vt[k].seq, vt[k].base, vt[k].bad, 0);
      end
      idle(4);
      e_frame = vt[k].x_frame; e_hdr = vt[k].x_hdr; e_crc = vt[k].x_crc; e_seq = vt[k].x_seq;
      check_counters($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_o_seq", k), o_seq, m_seq);
      chk($sformatf("vec%0d_o_status", k), o_status, m_status);
    end

    // back-to-back frames at full rate
    send_frame(8'h05, 32'd10, 32'h3000_0000, 0, 0);
    send_frame(8'h05, 32'd11, 32'h3100_0000, 0, 0);
    send_frame(8'h05, 32'd12, 32'h3200_0000, 0, 0);
    idle(4);
    e_frame += 3;
    check_counters("b2b");

    // stall after beat2: exactly TIMEOUT idle cycles aborts the frame
    build(16'hA55A, 8'h06, 8'd9, 32'd13, 32'h4000_0000, 0);
    for (int i = 0; i < 3; i++) drive_beat(beats[i]);
    idle(1023);
    chk("timeout_not_yet", o_timeout_cnt, 16'd0);
    idle(1);
    e_to = 1;
    chk("timeout_hit", o_timeout_cnt, 16'd1);
    send_frame(8'h06, 32'd13, 32'h4000_0000, 0, 0);
    idle(4);
    e_frame += 1;
    check_counters("after_timeout");

    // 1000-cycle gaps between beats stay inside the idle budget
    send_frame(8'h07, 32'd14, 32'h5000_0000, 0, 1000);
    idle(4);
    e_frame += 1;
    check_counters("gaps");

    // enable dropped at beat3: frame silently dropped
    build(16'hA55A, 8'h08, 8'd9, 32'd15, 32'h6000_0000, 0);
    for (int i = 0; i < 3; i++) drive_beat(beats[i]);
    s_peer_tdata = beats[3]; s_peer_tvalid = 1'b1; i_en = 1'b0;
    #1;
    chk("en_low_tready", s_peer_tready, 1'b0);
    @(negedge i_clk);
    idle(3);
    i_en = 1'b1;
    idle(2);
    check_counters("en_drop");
    send_frame(8'h08, 32'd15, 32'h6000_0000, 0, 0);
    idle(4);
    e_frame += 1;
    check_counters("en_resume");

    // asynchronous reset mid-frame
    build(16'hA55A, 8'h09, 8'd9, 32'd16, 32'h7000_0000, 0);
    for (int i = 0; i < 3; i++) drive_beat(beats[i]);
    s_peer_tvalid = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    chk("midrst_snapshot_zero", |{o_status, o_intl, o_c, o_v, o_dc_c, o_dc_v, o_phase_r,
                                  o_phase_s, o_phase_t, o_src_id, o_seq}, 1'b0);
    chk("midrst_counters_zero", |{o_frame_cnt, o_hdr_err_cnt, o_crc_err_cnt, o_seq_err_cnt,
                                  o_timeout_cnt}, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    e_frame = 0; e_hdr = 0; e_crc = 0; e_seq = 0; e_to = 0;
    idle(2);
    // prior-frame flag was cleared, so an arbitrary sequence is not a gap
    send_frame(8'h0A, 32'd100, 32'h8000_0000, 0, 0);
    idle(4);
    e_frame = 1;
    check_counters("post_rst");
    chk("post_rst_o_seq", o_seq, 32'd100);

    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/sfp_peer_frame_unpacker.md
# sfp_peer_frame_unpacker

Consumes the 64-bit AXI-Stream telemetry frames delivered on the SFP handler's peer master stream and reconstructs the nine 32-bit status words of the remote MPS. It sits directly downstream of the SFP top-level peer output port, in the same 200 MHz domain. It validates header, checksum and sequence continuity, and publishes a coherent snapshot plus link-health counters to the register/interlock logic.

## Interface
- SYNC_WORD, 16'hA55A, required value of header bits [63:48]
- TIMEOUT, 1024, maximum idle cycles between beats inside a frame before abort (≥2)
- i_clk  in  1  stream and logic clock
- i_rst  in  1  asynchronous, active-low reset
- i_en  in  1  unpacker enable; low forces HUNT and deasserts tready
- s_peer_tdata  in  64  frame beat
- s_peer_tvalid  in  1  beat valid
- s_peer_tready  out  1  = i_en registered-free (combinational from i_en)
- o_status, o_intl, o_c, o_v, o_dc_c, o_dc_v, o_phase_r, o_phase_s, o_phase_t  out  32 each  last good snapshot
- o_src_id  out  8  source-id field of last good frame
- o_seq  out  32  sequence number of last good frame
- o_frame_valid  out  1  one-cycle pulse on snapshot commit
- o_frame_cnt, o_hdr_err_cnt, o_crc_err_cnt, o_seq_err_cnt, o_timeout_cnt  out  16 each  wrapping event counters

## Operation
- Frame = 6 beats. Beat0 header: [63:48]=SYNC_WORD, [47:40]=source id, [39:32]=word count (must be 9), [31:0]=sequence. Beat1 {status,intl}, beat2 {c,v}, beat3 {dc_c,dc_v}, beat4 {phase_r,phase_s}, beat5 {phase_t,checksum}; upper half is the first-named word.
- Checksum = XOR of header[63:32], header[31:0] and the nine data words.
- Beat accepted when s_peer_tvalid & s_peer_tready.
- States: HUNT, DATA, COMMIT.
- HUNT: accepted beat with sync and count=9 → latch header into shadow, clear beat index to 1, running XOR = hdr hi ^ hdr lo, go DATA. Any other accepted beat → discard, o_hdr_err_cnt+1, stay HUNT.
- DATA: each accepted beat stored into shadow registers by index; no resync on sync pattern (treated as data). On beat5 compare final XOR with checksum: match → COMMIT; mismatch → o_crc_err_cnt+1, HUNT, outputs unchanged.
- DATA idle counter resets on each accepted beat; reaching TIMEOUT → o_timeout_cnt+1, HUNT, partial frame dropped.
- COMMIT (one cycle): copy shadow to all outputs, pulse o_frame_valid, o_frame_cnt+1; if a prior good frame exists and seq ≠ previous seq+1 (mod 2^32), o_seq_err_cnt+1 (frame still committed). Return to HUNT. s_peer_tready stays high; a beat accepted in COMMIT is processed with HUNT rules.
- i_en low: immediate HUNT, partial frame dropped with no counter change; outputs and counters hold.
- Counters wrap 16'hFFFF→0.

## Timing
- Reset: all outputs 0, state HUNT, "prior good frame" flag clear; s_peer_tready follows i_en even during reset release.
- Latency: snapshot outputs and o_frame_valid change on the clock edge after the edge accepting beat5 (1 cycle).
- Snapshot outputs change only in COMMIT; all nine words update on the same edge (coherent).
- Error counters update on the edge after the offending beat / timeout expiry.
- Back-to-back frames at one beat per cycle sustained without loss (COMMIT overlaps the next header).
- Reset asserted mid-frame: immediate clear, no partial commit.

## Test plan
- Good frame: id=0x02, seq=5, words 0x1000_0001..0x1000_0009, correct XOR, tvalid every cycle → outputs equal words one cycle after beat5, o_frame_valid single pulse, o_frame_cnt=1.
- Checksum corrupted (bit 0 flipped) → outputs stay 0, o_crc_err_cnt=1, next good frame commits normally.
- Bad header (sync 0x5AA5, then count=8) → both discarded, o_hdr_err_cnt=2, following valid frame accepted.
- Sequence 5,6,8 all valid → three commits, o_seq_err_cnt=1, o_seq=8.
- Stall 1024 cycles after beat2 → o_timeout_cnt=1, then complete frame accepted; also tvalid gaps of 1000 cycles never trigger timeout.
- i_en dropped at beat3, raised, full frame sent → no counter change from the drop, one commit; async reset mid-frame → all outputs 0.
